// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single memory bus port between instruction fetch
//                (IF) and the load/store path (LS). One outstanding
//                transaction; LS has priority, and IF is forced through after
//                MAX_LS_STREAK consecutive LS wins. Fetch responses belonging
//                to a flushed fetch are discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int XLEN          = 32,
   parameter int MAX_LS_STREAK = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush_i,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_adr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [31:0]     if_rdata_o,
   input  logic            ls_req_i,
   input  logic [XLEN-1:0] ls_adr_i,
   input  logic            ls_we_i,
   input  logic [XLEN-1:0] ls_wdata_i,
   input  logic [2:0]      ls_size_i,
   output logic            ls_gnt_o,
   output logic            ls_rvalid_o,
   output logic [XLEN-1:0] ls_rdata_o,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_adr_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [2:0]      mem_size_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   // Streak counter only needs to reach MAX_LS_STREAK, where it saturates.
   localparam int                c_SW         = $clog2(MAX_LS_STREAK + 1);
   localparam logic [c_SW-1:0]   c_STREAK_MAX = c_SW'(MAX_LS_STREAK);

   localparam logic [1:0]        c_IDLE       = 2'd0;
   localparam logic [1:0]        c_REQ        = 2'd1;
   localparam logic [1:0]        c_RESP       = 2'd2;

   // Fetches are always word reads.
   localparam logic [2:0]        c_IF_SIZE    = 3'b010;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_owner_if;    // 1 = IF owns the bus, 0 = LS
   logic             r_kill;        // current IF transaction was flushed
   logic [c_SW-1:0]  r_streak;
   logic [XLEN-1:0]  r_adr;
   logic [XLEN-1:0]  r_wdata;
   logic             r_we;
   logic [2:0]       r_size;

   logic             w_if_elig;
   logic             w_any_elig;
   logic             w_pick_if;

   // A flush in the arbitration cycle means the fetch address is stale.
   assign w_if_elig  = if_req_i & ~flush_i;
   assign w_any_elig = w_if_elig | ls_req_i;
   assign w_pick_if  = w_if_elig & (~ls_req_i | (r_streak == c_STREAK_MAX));

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: arbitrate in IDLE, wait for grant, then wait for response.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_any_elig)   w_state_nxt = c_REQ;
         c_REQ:   if (mem_gnt_i)    w_state_nxt = c_RESP;
         c_RESP:  if (mem_rvalid_i) w_state_nxt = c_IDLE;
         default:                   w_state_nxt = c_IDLE;
      endcase
   end

   // Latch the winner's payload and maintain the LS streak count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_owner_if <= 1'b0;
         r_streak   <= '0;
         r_adr      <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_size     <= 3'b000;
      end else if (r_state == c_IDLE && w_any_elig) begin
         r_owner_if <= w_pick_if;
         if (w_pick_if) begin
            r_streak <= '0;
            r_adr    <= if_adr_i;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_size   <= c_IF_SIZE;
         end else begin
            // Only LS wins that make a waiting fetch wait count as streak.
            if (if_req_i && (r_streak != c_STREAK_MAX)) begin
               r_streak <= r_streak + 1'b1;
            end
            r_adr   <= ls_adr_i;
            r_wdata <= ls_wdata_i;
            r_we    <= ls_we_i;
            r_size  <= ls_size_i;
         end
      end
   end

   // Kill flag: remember a flush that hit an in-flight fetch until it retires.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_kill <= 1'b0;
      end else if (r_state == c_RESP && mem_rvalid_i) begin
         r_kill <= 1'b0;
      end else if ((r_state == c_REQ || r_state == c_RESP) && r_owner_if && flush_i) begin
         r_kill <= 1'b1;
      end
   end

   // Outputs: bus request plus same-cycle grant/response steering to the owner.
   always_comb begin
      mem_req_o   = 1'b0;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
      case (r_state)
         c_REQ: begin
            mem_req_o = 1'b1;
            if_gnt_o  = mem_gnt_i &  r_owner_if & ~r_kill;
            ls_gnt_o  = mem_gnt_i & ~r_owner_if;
         end
         c_RESP: begin
            if_rvalid_o = mem_rvalid_i &  r_owner_if & ~r_kill & ~flush_i;
            ls_rvalid_o = mem_rvalid_i & ~r_owner_if;
         end
         default: ;
      endcase
   end

   assign mem_adr_o   = r_adr;
   assign mem_we_o    = r_we;
   assign mem_wdata_o = r_wdata;
   assign mem_size_o  = r_size;

   assign if_rdata_o  = mem_rdata_i[31:0];
   assign ls_rdata_o  = mem_rdata_i;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory bus port between instruction fetch (IF) and the load/store path of exe (LS).
- Sits between ifetch/exe and the memory subsystem. Handles one outstanding transaction at a time.
- LS has priority over IF, with starvation protection for IF.
- Discards in-flight fetch responses when a branch or exception flushes the front end.

Parameters:
XLEN, 32, address/data width
MAX_LS_STREAK, 4, consecutive LS wins over a pending IF before IF is forced; must be >= 1

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush_i  in  1  branch/exception pulse from exe; kills the current IF transaction
if_req_i  in  1  fetch request; held with if_adr_i stable until if_gnt_o
if_adr_i  in  XLEN  fetch address
if_gnt_o  out  1  fetch request accepted
if_rvalid_o  out  1  fetch data valid
if_rdata_o  out  32  fetch instruction
ls_req_i  in  1  load/store request; held with payload stable until ls_gnt_o
ls_adr_i  in  XLEN  access address
ls_we_i  in  1  1 = store
ls_wdata_i  in  XLEN  store data
ls_size_i  in  3  access size code, passed through unchanged
ls_gnt_o  out  1  LS request accepted
ls_rvalid_o  out  1  load data valid / store acknowledged
ls_rdata_o  out  XLEN  load data
mem_req_o  out  1  bus request
mem_adr_o  out  XLEN  bus address
mem_we_o  out  1  bus write enable
mem_wdata_o  out  XLEN  bus write data
mem_size_o  out  3  bus access size
mem_gnt_i  in  1  bus accepted request
mem_rvalid_i  in  1  bus response valid (reads and writes)
mem_rdata_i  in  XLEN  bus read data

Behaviour:
- Reset is on reset_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state = IDLE; owner = LS; streak counter = 0; kill flag = 0.
  - All mem_* outputs = 0; all gnt/rvalid outputs = 0.
- State IDLE:
  - IF is eligible when if_req_i=1 and flush_i=0.
  - If only one requester is eligible, pick it.
  - If both are eligible, pick LS unless streak == MAX_LS_STREAK; in that case pick IF.
  - Latch the owner and its payload into the mem_* registers (IF: we=0, wdata=0, size=3'b010). Next state is REQ.
  - No eligible requester: stay in IDLE.
- State REQ:
  - mem_req_o = 1 with the registered payload.
  - When mem_gnt_i=1: pulse the owner's gnt for that same cycle (combinational from mem_gnt_i), drop mem_req_o next cycle, and go to RESP.
  - If the kill flag is set, if_gnt_o is suppressed.
- State RESP:
  - When mem_rvalid_i=1: assert the owner's rvalid for that cycle (combinational) and go to IDLE.
  - If_rvalid_o is suppressed when the kill flag is set or flush_i=1 that cycle.
  - The kill flag clears on leaving RESP.
- Data path: if_rdata_o = mem_rdata_i[31:0]; ls_rdata_o = mem_rdata_i. Both are meaningful only with their rvalid.
- Latency:
  - Minimum request-sampled to rvalid is 3 cycles (IDLE, REQ with gnt, RESP with rvalid).
  - Back-to-back transactions are separated by one IDLE cycle.
- Streak counter:
  - Increments (saturating at MAX_LS_STREAK) when LS is picked while if_req_i=1.
  - Clears when IF is picked.
  - Unchanged when LS is picked with no IF request.
- Flush:
  - flush_i in REQ or RESP with owner=IF sets the kill flag; the bus transaction still completes normally.
  - flush_i never affects LS transactions.
  - flush_i in IDLE only blocks IF eligibility that cycle.
- Simultaneous events:
  - mem_gnt_i and mem_rvalid_i in the same REQ cycle: rvalid is ignored; the memory must not respond before gnt.
  - flush_i in the same cycle as mem_rvalid_i for IF: the response is dropped.
- Requests released before grant: a requester deasserting req before gnt is a protocol violation; the latched transaction still completes.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no response delivered. The memory must also be reset.

Test Plan:
- IF only, if_adr_i=0x80000000, gnt and rvalid immediate, rdata=0x00000013 -> if_gnt_o at cycle 1, if_rvalid_o=1 with if_rdata_o=0x00000013 at cycle 2, mem_we_o=0.
- Store, adr=0x1000, wdata=0xDEADBEEF, size=3'b010, mem_gnt_i delayed 3 cycles -> mem_req_o held 4 cycles with stable payload, then ls_gnt_o pulse, then ls_rvalid_o on the ack.
- Both requesting continuously, MAX_LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- IF in RESP, flush_i pulse 2 cycles before mem_rvalid_i -> if_rvalid_o stays 0; next IF request to 0x80000100 is served normally.
- LS in RESP with flush_i=1 alongside mem_rvalid_i, load data 0x12345678 -> ls_rvalid_o=1 with 0x12345678.
- reset_n low during REQ -> same-cycle mem_req_o=0 and all gnt/rvalid=0; after release, state IDLE and streak=0.
